wifi_tx_arbiter: RTL and testbench



---
 rtl/wifi_tx_arbiter.sv | 137 +++++++++++++
 tb/tb_wifi_tx_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/wifi_tx_arbiter.sv
// Two-requester front end for the shared WiFi UART send engine.
// Define WIFI_ARB_ROUND_ROBIN_EN for round robin; default is fixed priority (req0).
module wifi_tx_arbiter #(
  parameter int START_HOLD  = 2,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_dato,
  input  logic [7:0] req0_cmd,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_dato,
  input  logic [7:0] req1_cmd,
  output logic       req1_ready,
  output logic [7:0] eng_dato,
  output logic [7:0] eng_comando,
  output logic       eng_start,
  input  logic       eng_bussy,
  output logic       busy,
  output logic       last_grant,
  output logic       timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_RISE,
    S_WAIT_FALL
  } state_t;

  localparam logic [3:0]  HOLD_INIT = 4'(START_HOLD - 1);
  localparam logic [23:0] TO_LAST   = 24'(TIMEOUT_CYC - 1);

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_hold, w_hold_nxt;
  logic [23:0] r_cnt, w_cnt_nxt;
  logic [7:0]  r_dato, w_dato_nxt;
  logic [7:0]  r_cmd, w_cmd_nxt;
  logic        r_start, w_start_nxt;
  logic        r_to, w_to_nxt;
  logic        r_last, w_last_nxt;
  logic        w_grant;
  logic        w_idle_ok;
  logic        w_xfer;

  assign w_idle_ok = (r_state == S_IDLE) && !eng_bussy && !rst;

  always_comb begin
    w_grant = !req0_valid;
`ifdef WIFI_ARB_ROUND_ROBIN_EN
    if (req0_valid && req1_valid) w_grant = ~r_last;
`endif
  end

  assign req0_ready = w_idle_ok && !w_grant;
  assign req1_ready = w_idle_ok && w_grant;
  assign w_xfer     = (req0_valid && req0_ready) ||
                      (req1_valid && req1_ready);

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    w_cnt_nxt   = r_cnt;
    w_dato_nxt  = r_dato;
    w_cmd_nxt   = r_cmd;
    w_start_nxt = r_start;
    w_to_nxt    = 1'b0;
    w_last_nxt  = r_last;
    unique case (r_state)
      S_IDLE: begin
        if (w_xfer) begin
          w_dato_nxt  = w_grant ? req1_dato : req0_dato;
          w_cmd_nxt   = w_grant ? req1_cmd : req0_cmd;
          w_last_nxt  = w_grant;
          w_hold_nxt  = HOLD_INIT;
          w_start_nxt = 1'b1;
          w_state_nxt = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (r_hold == 4'd0) begin
          w_start_nxt = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_WAIT_RISE;
        end else begin
          w_hold_nxt = r_hold - 4'd1;
        end
      end
      S_WAIT_RISE, S_WAIT_FALL: begin
        // Rise ends WAIT_RISE, fall ends WAIT_FALL; both share one timeout.
        if ((r_state == S_WAIT_RISE) == eng_bussy) begin
          w_cnt_nxt   = '0;
          w_state_nxt = eng_bussy ? S_WAIT_FALL : S_IDLE;
        end else if (r_cnt == TO_LAST) begin
          w_cnt_nxt   = '0;
          w_to_nxt    = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 24'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_hold  <= '0;
      r_cnt   <= '0;
      r_dato  <= '0;
      r_cmd   <= '0;
      r_start <= 1'b0;
      r_to    <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_hold_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dato  <= w_dato_nxt;
      r_cmd   <= w_cmd_nxt;
      r_start <= w_start_nxt;
      r_to    <= w_to_nxt;
      r_last  <= w_last_nxt;
    end
  end

  assign eng_dato    = r_dato;
  assign eng_comando = r_cmd;
  assign eng_start   = r_start;
  assign timeout_err = r_to;
  assign last_grant  = r_last;
  assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_wifi_tx_arbiter.sv
// Self-checking bench for wifi_tx_arbiter with a small engine stand-in
// and a pending-request arbitration model.
module tb_wifi_tx_arbiter;

  localparam int SH = 2;
  localparam int TO = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_dato, req0_cmd, req1_dato, req1_cmd;
  logic       req0_ready, req1_ready;
  logic [7:0] eng_dato, eng_comando;
  logic       eng_start, eng_bussy;
  logic       busy, last_grant, timeout_err;

  int errors = 0;
  int checks = 0;
  int m_last = 1;
  bit p0, p1;
  int g;
  int seq[4];

  always #5 clk = ~clk;

  wifi_tx_arbiter #(.START_HOLD(SH), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_dato(req0_dato),
    .req0_cmd(req0_cmd), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_dato(req1_dato),
    .req1_cmd(req1_cmd), .req1_ready(req1_ready),
    .eng_dato(eng_dato), .eng_comando(eng_comando),
    .eng_start(eng_start), .eng_bussy(eng_bussy),
    .busy(busy), .last_grant(last_grant),
    .timeout_err(timeout_err)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant(bit v0, bit v1, int last);
`ifdef WIFI_ARB_ROUND_ROBIN_EN
    if (v0 && v1) return 1 - last;
`endif
    return v0 ? 0 : 1;
  endfunction

  task automatic launch(input int gi, input bit keep);
    logic [7:0] ed, ec;
    int n;
    n = 0;
    while (((gi == 0) ? req0_ready : req1_ready) !== 1'b1 && n < 30) begin
      step;
      n++;
    end
    chk("rdy_win", (gi == 0) ? req0_ready : req1_ready, 1);
    chk("rdy_lose", (gi == 0) ? req1_ready : req0_ready, 0);
    ed = (gi == 0) ? req0_dato : req1_dato;
    ec = (gi == 0) ? req0_cmd : req1_cmd;
    step;
    if (!keep) begin
      if (gi == 0) req0_valid = 1'b0;
      else req1_valid = 1'b0;
    end
    m_last = gi;
    chk("eng_dato", eng_dato, ed);
    chk("eng_cmd", eng_comando, ec);
    chk("last_grant", last_grant, gi);
    chk("busy_launch", busy, 1);
    chk("start_first", eng_start, 1);
    n = 0;
    while (eng_start === 1'b1 && n < 20) begin
      n++;
      step;
    end
    chk("start_len", n, SH);
    chk("busy_after_start", busy, 1);
  endtask

  task automatic engine(input int dly, input int len);
    repeat (dly) step;
    eng_bussy = 1'b1;
    repeat (len) step;
    chk("busy_wfall", busy, 1);
    eng_bussy = 1'b0;
    #1;
    chk("busy_hold", busy, 1);
    step;
    chk("busy_fall", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    eng_bussy = 1'b0;
    req0_valid = 1'b1;
    req0_dato = 8'h41;
    req0_cmd = 8'h02;
    req1_valid = 1'b0;
    req1_dato = 8'h00;
    req1_cmd = 8'h00;
    repeat (3) step;
    chk("rst_start", eng_start, 0);
    chk("rst_dato", eng_dato, 0);
    chk("rst_cmd", eng_comando, 0);
    chk("rst_busy", busy, 0);
    chk("rst_last", last_grant, 1);
    chk("rst_to", timeout_err, 0);
    chk("rst_rdy0", req0_ready, 0);
    chk("rst_rdy1", req1_ready, 0);
    rst = 1'b0;
    #1;

    launch(0, 0);
    engine(3, 10);

    rst = 1'b1;
    step;
    rst = 1'b0;
    m_last = 1;
`ifdef WIFI_ARB_ROUND_ROBIN_EN
    seq = '{0, 1, 0, 1};
`else
    seq = '{0, 0, 0, 0};
`endif
    req0_dato = 8'h11; req0_cmd = 8'h01;
    req1_dato = 8'h22; req1_cmd = 8'h03;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("rr_model", model_grant(1, 1, m_last), seq[i]);
      launch(seq[i], 1);
      engine(1, 1);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    eng_bussy = 1'b1;
    req1_dato = 8'h77; req1_cmd = 8'h09; req1_valid = 1'b1;
    #1;
    repeat (3) begin
      chk("bsy_rdy1", req1_ready, 0);
      chk("bsy_rdy0", req0_ready, 0);
      step;
    end
    chk("bsy_idle", busy, 0);
    eng_bussy = 1'b0;
    #1;
    chk("bsy_drop_rdy1", req1_ready, 1);
    launch(1, 0);
    engine(1, 3);

    req0_dato = 8'h55; req0_cmd = 8'h07; req0_valid = 1'b1;
    launch(0, 0);
    begin
      int n;
      n = 0;
      while (timeout_err !== 1'b1 && n < 40) begin
        step;
        n++;
      end
      chk("to_latency", n, TO);
      chk("to_idle", busy, 0);
      step;
      chk("to_pulse_end", timeout_err, 0);
    end
    req1_dato = 8'h99; req1_cmd = 8'h0A; req1_valid = 1'b1;
    launch(1, 0);
    engine(2, 2);

    req0_dato = 8'h66; req0_cmd = 8'h05; req0_valid = 1'b1;
    #1;
    chk("mr_rdy", req0_ready, 1);
    step;
    req0_valid = 1'b0;
    chk("mr_start", eng_start, 1);
    rst = 1'b1;
    #1;
    chk("mr_rdy_rst", req0_ready, 0);
    step;
    chk("mr_start0", eng_start, 0);
    chk("mr_dato0", eng_dato, 0);
    chk("mr_busy0", busy, 0);
    chk("mr_last1", last_grant, 1);
    chk("mr_to0", timeout_err, 0);
    rst = 1'b0;
    m_last = 1;
    step;
    chk("mr_to_after", timeout_err, 0);

    p0 = 1'b0; p1 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (!p0 && ($urandom_range(0, 1) == 1 || !p1)) begin
        p0 = 1'b1;
        req0_dato = 8'($urandom);
        req0_cmd = 8'($urandom);
        req0_valid = 1'b1;
      end
      if (!p1 && $urandom_range(0, 1) == 1) begin
        p1 = 1'b1;
        req1_dato = 8'($urandom);
        req1_cmd = 8'($urandom);
        req1_valid = 1'b1;
      end
      #1;
      g = model_grant(p0, p1, m_last);
      launch(g, 0);
      if (g == 0) p0 = 1'b0;
      else p1 = 1'b0;
      engine($urandom_range(0, 8), $urandom_range(1, 6));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
